rst_seq_ctrl: RTL and testbench
===============================

RST_SEQ_CTRL -- requirements
Module: rst_seq_ctrl

Interface
REQ-001 Parameter NUM_DOMAINS, default 3, number of sequenced reset domains (range 1..8).
REQ-002 Parameter HOLD_CYCLES, default 16, CLK cycles all domain resets stay asserted before the first release (range 1..255).
REQ-003 Parameter ACK_TIMEOUT, default 255, maximum CLK cycles waited for one domain acknowledge (range 1..255).
REQ-004 CLK  input  1  clock.
REQ-005 RST  input  1  reset, asynchronous, active-low.
REQ-006 SW_RST_REQ  input  1  software reset request, sampled every CLK edge, level-sensitive.
REQ-007 DOM_ACK  input  NUM_DOMAINS  per-domain "out of reset" status, already synchronized into CLK domain; 1 = domain released.
REQ-008 DOM_RST_N  output  NUM_DOMAINS  registered active-low reset request to each domain's reset synchronizer.
REQ-009 SYS_READY  output  1  all domains released and acknowledged.
REQ-010 BUSY  output  1  sequence in progress (HOLD, RELEASE or WAIT_ACK).
REQ-011 TIMEOUT_ERR  output  1  acknowledge timeout flag.
REQ-012 ERR_DOM  output  3  index of the domain that timed out.

Function
REQ-013 FSM states SHALL be HOLD, RELEASE, WAIT_ACK, READY and ERROR; all outputs registered.
REQ-014 HOLD SHALL keep all DOM_RST_N low, increment the shared counter each edge, and go to RELEASE on the edge where counter = HOLD_CYCLES-1, clearing the counter.
REQ-015 RELEASE SHALL last one cycle; its exit edge sets DOM_RST_N[idx]=1, clears the counter and enters WAIT_ACK.
REQ-016 Domains SHALL be released strictly in ascending index order, domain 0 first; released bits stay high until the next restart.
REQ-017 WAIT_ACK with DOM_ACK[idx]=1 SHALL go to READY when idx = NUM_DOMAINS-1, else increment idx and go to RELEASE.
REQ-018 DOM_ACK bits other than DOM_ACK[idx] SHALL be ignored outside READY.
REQ-019 READY SHALL drive SYS_READY=1 and BUSY=0; BUSY=1 in HOLD, RELEASE and WAIT_ACK; SYS_READY=0 in every other state.
REQ-020 A restart, meaning all DOM_RST_N low, SYS_READY=0, idx=0, counter=0 and next state HOLD, SHALL occur on the edge after SW_RST_REQ=1 in any state.
REQ-021 In READY, any DOM_ACK bit low SHALL cause a restart, treated as an unexpected domain reset.
REQ-022 SW_RST_REQ SHALL have priority over DOM_ACK and over timeout in the same cycle.
REQ-023 With SW_RST_REQ held high, the FSM SHALL remain in HOLD with the counter held at 0.

Reset
REQ-024 RST low SHALL asynchronously force state HOLD, DOM_RST_N all 0, SYS_READY=0, BUSY=1, TIMEOUT_ERR=0, ERR_DOM=0, idx=0 and counter=0.
REQ-025 Reset SHALL take effect mid-sequence from any state with no residual released domain.

Configuration
REQ-026 Macro RST_SEQ_TIMEOUT_EN defined: WAIT_ACK SHALL count cycles, and DOM_ACK[idx] still 0 when counter = ACK_TIMEOUT-1 SHALL cause entry to ERROR on that edge.
REQ-027 On entering ERROR, TIMEOUT_ERR SHALL be 1, ERR_DOM SHALL be idx and DOM_RST_N SHALL be all 0.
REQ-028 ERROR SHALL be left only via SW_RST_REQ, which restarts the sequence and clears TIMEOUT_ERR and ERR_DOM.
REQ-029 Macro RST_SEQ_TIMEOUT_EN undefined: WAIT_ACK SHALL wait indefinitely, the ERROR state SHALL be absent, and TIMEOUT_ERR and ERR_DOM SHALL be constant 0.

Structure
REQ-030 Package rst_seq_pkg SHALL hold the state enum typedef, default parameter constants and the ERR_DOM width constant.
REQ-031 A sub-module rst_seq_cnt SHALL implement the 8-bit clear/increment counter shared by HOLD and timeout counting.

Verification
REQ-032 Release with NUM_DOMAINS=3, HOLD_CYCLES=4 and DOM_ACK echoing DOM_RST_N one cycle later -> DOM_RST_N[0] rises at edge 5 after RST deassert, [1] at edge 8, [2] at edge 11, and SYS_READY rises at edge 13.
REQ-033 SW_RST_REQ pulsed 1 cycle in READY -> the next edge gives DOM_RST_N=000, SYS_READY=0, BUSY=1, and a full sequence repeats.
REQ-034 DOM_ACK[1] forced to 0 in READY -> restart on the next edge, then domains re-release 0,1,2.
REQ-035 RST_SEQ_TIMEOUT_EN defined, ACK_TIMEOUT=10, DOM_ACK[1] stuck 0 -> ERROR 10 cycles after DOM_RST_N[1] rises, TIMEOUT_ERR=1, ERR_DOM=1, DOM_RST_N=000; a following SW_RST_REQ clears the error.
REQ-036 RST asserted during WAIT_ACK of domain 2 -> all outputs immediately at reset values without waiting for a CLK edge.
REQ-037 SW_RST_REQ and DOM_ACK[idx] high in the same WAIT_ACK cycle -> restart wins and idx returns to 0.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// ============================================================================
// rst_seq_pkg : shared types and defaults for the reset sequencer
//               (state set depends on macro RST_SEQ_TIMEOUT_EN)
// Rev 1.0
// ============================================================================
`default_nettype none

package rst_seq_pkg;

    localparam int DEF_NUM_DOMAINS = 3;
    localparam int DEF_HOLD_CYCLES = 16;
    localparam int DEF_ACK_TIMEOUT = 255;
    localparam int ERR_DOM_W       = 3;
    localparam int CNT_W           = 8;

    typedef enum logic [2:0] {
        ST_HOLD     = 3'd0,
        ST_RELEASE  = 3'd1,
        ST_WAIT_ACK = 3'd2,
        ST_READY    = 3'd3
`ifdef RST_SEQ_TIMEOUT_EN
        ,
        ST_ERROR    = 3'd4
`endif
    } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/rst_seq_cnt.sv
// ============================================================================
// rst_seq_cnt : 8-bit clear/increment counter shared by hold and ack timing
// Rev 1.0
// ============================================================================
`default_nettype none

module rst_seq_cnt
    import rst_seq_pkg::*;
(
    input  logic             CLK,
    input  logic             RST,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Clear dominates so the sequencer can park the counter at zero.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/rst_seq_ctrl.sv
// ============================================================================
// rst_seq_ctrl : ordered per-domain reset release with ack handshake
//                (optional ack timeout via macro RST_SEQ_TIMEOUT_EN)
// Rev 1.0
// ============================================================================
`default_nettype none

module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int NUM_DOMAINS = DEF_NUM_DOMAINS,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   SW_RST_REQ,
    input  logic [NUM_DOMAINS-1:0] DOM_ACK,
    output logic [NUM_DOMAINS-1:0] DOM_RST_N,
    output logic                   SYS_READY,
    output logic                   BUSY,
    output logic                   TIMEOUT_ERR,
    output logic [ERR_DOM_W-1:0]   ERR_DOM
);

    localparam logic [CNT_W-1:0]     HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [ERR_DOM_W-1:0] LAST_IDX  = ERR_DOM_W'(NUM_DOMAINS - 1);

    generate
        if (NUM_DOMAINS < 1 || NUM_DOMAINS > 8) begin : g_bad_num_domains
            $error("rst_seq_ctrl: NUM_DOMAINS must be 1..8");
        end
        if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold_cycles
            $error("rst_seq_ctrl: HOLD_CYCLES must be 1..255");
        end
        if (ACK_TIMEOUT < 1 || ACK_TIMEOUT > 255) begin : g_bad_ack_timeout
            $error("rst_seq_ctrl: ACK_TIMEOUT must be 1..255");
        end
    endgenerate

    seq_state_t             state;
    logic [ERR_DOM_W-1:0]   idx;
    logic [CNT_W-1:0]       cnt;
    logic                   cnt_clr;
    logic                   cnt_inc;
    logic [NUM_DOMAINS-1:0] sel;
    logic                   ack_sel;
    logic                   all_ack;
    logic                   hold_done;
    logic                   restart;

    // One-hot of the domain currently being released/awaited; other ack bits are don't-care.
    assign sel       = NUM_DOMAINS'(1) << idx;
    assign ack_sel   = |(DOM_ACK & sel);
    assign all_ack   = &DOM_ACK;
    assign hold_done = (cnt == HOLD_LAST);

    // A domain dropping its ack while READY is an unexpected domain reset.
    assign restart   = SW_RST_REQ || ((state == ST_READY) && !all_ack);

`ifdef RST_SEQ_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(ACK_TIMEOUT - 1);

    logic to_hit;
    assign to_hit = (cnt == TO_LAST);
`endif

    always_comb begin
        cnt_clr = 1'b1;
        cnt_inc = 1'b0;
        if (!restart) begin
            case (state)
                ST_HOLD: begin
                    if (!hold_done) begin
                        cnt_clr = 1'b0;
                        cnt_inc = 1'b1;
                    end
                end
`ifdef RST_SEQ_TIMEOUT_EN
                ST_WAIT_ACK: begin
                    if (!ack_sel && !to_hit) begin
                        cnt_clr = 1'b0;
                        cnt_inc = 1'b1;
                    end
                end
`endif
                default: begin
                    cnt_clr = 1'b1;
                    cnt_inc = 1'b0;
                end
            endcase
        end
    end

    rst_seq_cnt u_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .count (cnt)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= ST_HOLD;
            idx         <= '0;
            DOM_RST_N   <= '0;
            SYS_READY   <= 1'b0;
            BUSY        <= 1'b1;
`ifdef RST_SEQ_TIMEOUT_EN
            TIMEOUT_ERR <= 1'b0;
            ERR_DOM     <= '0;
`endif
        end else if (restart) begin
            state       <= ST_HOLD;
            idx         <= '0;
            DOM_RST_N   <= '0;
            SYS_READY   <= 1'b0;
            BUSY        <= 1'b1;
`ifdef RST_SEQ_TIMEOUT_EN
            TIMEOUT_ERR <= 1'b0;
            ERR_DOM     <= '0;
`endif
        end else begin
            case (state)
                ST_HOLD: begin
                    if (hold_done) begin
                        state <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    DOM_RST_N <= DOM_RST_N | sel;
                    state     <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (ack_sel) begin
                        if (idx == LAST_IDX) begin
                            state     <= ST_READY;
                            SYS_READY <= 1'b1;
                            BUSY      <= 1'b0;
                        end else begin
                            idx   <= idx + ERR_DOM_W'(1);
                            state <= ST_RELEASE;
                        end
                    end
`ifdef RST_SEQ_TIMEOUT_EN
                    else if (to_hit) begin
                        state       <= ST_ERROR;
                        BUSY        <= 1'b0;
                        DOM_RST_N   <= '0;
                        TIMEOUT_ERR <= 1'b1;
                        ERR_DOM     <= idx;
                    end
`endif
                end
                ST_READY: begin
                    state <= ST_READY;
                end
`ifdef RST_SEQ_TIMEOUT_EN
                ST_ERROR: begin
                    state <= ST_ERROR;
                end
`endif
                default: begin
                    state     <= ST_HOLD;
                    idx       <= '0;
                    DOM_RST_N <= '0;
                    SYS_READY <= 1'b0;
                    BUSY      <= 1'b1;
                end
            endcase
        end
    end

`ifndef RST_SEQ_TIMEOUT_EN
    assign TIMEOUT_ERR = 1'b0;
    assign ERR_DOM     = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rst_seq_ctrl.sv
// ============================================================================
// tb_rst_seq_ctrl : scoreboard bench for rst_seq_ctrl (N=3, HOLD=4, TO=10)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_rst_seq_ctrl;

    localparam int N    = 3;
    localparam int HOLD = 4;
    localparam int ATO  = 10;
`ifdef RST_SEQ_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic         SW_RST_REQ = 1'b0;
    logic [N-1:0] DOM_ACK = '0;
    logic [N-1:0] DOM_RST_N;
    logic         SYS_READY;
    logic         BUSY;
    logic         TIMEOUT_ERR;
    logic [2:0]   ERR_DOM;

    rst_seq_ctrl #(
        .NUM_DOMAINS (N),
        .HOLD_CYCLES (HOLD),
        .ACK_TIMEOUT (ATO)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .SW_RST_REQ  (SW_RST_REQ),
        .DOM_ACK     (DOM_ACK),
        .DOM_RST_N   (DOM_RST_N),
        .SYS_READY   (SYS_READY),
        .BUSY        (BUSY),
        .TIMEOUT_ERR (TIMEOUT_ERR),
        .ERR_DOM     (ERR_DOM)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [N-1:0] dom;
        logic         rdy;
        logic         busy;
        logic         terr;
        logic [2:0]   edom;
    } obs_t;

    localparam obs_t RST_OBS = {3'b000, 1'b0, 1'b1, 1'b0, 3'd0};

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: progress counted in released domains and elapsed cycles.
    bit m_holding, m_releasing, m_ready, m_err;
    int m_hold_elapsed, m_released, m_waited, m_err_idx;

    function automatic void model_restart();
        m_holding      = 1'b1;
        m_hold_elapsed = 0;
        m_released     = 0;
        m_releasing    = 1'b0;
        m_waited       = 0;
        m_ready        = 1'b0;
        m_err          = 1'b0;
        m_err_idx      = 0;
    endfunction

    function automatic void model_step(input bit sw, input logic [N-1:0] ack);
        if (sw) begin
            model_restart();
        end else if (m_err) begin
            m_err = 1'b1;
        end else if (m_ready) begin
            if (ack != '1) model_restart();
        end else if (m_holding) begin
            m_hold_elapsed++;
            if (m_hold_elapsed == HOLD) begin
                m_holding   = 1'b0;
                m_releasing = 1'b1;
            end
        end else if (m_releasing) begin
            m_released++;
            m_releasing = 1'b0;
            m_waited    = 0;
        end else if (ack[m_released-1]) begin
            if (m_released == N) m_ready = 1'b1;
            else m_releasing = 1'b1;
        end else begin
            m_waited++;
            if (TO_EN && m_waited == ATO) begin
                m_err      = 1'b1;
                m_err_idx  = m_released - 1;
                m_released = 0;
            end
        end
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        o.dom  = m_err ? '0 : N'((1 << m_released) - 1);
        o.rdy  = m_ready;
        o.busy = !m_ready && !m_err;
        o.terr = m_err;
        o.edom = 3'(m_err_idx);
        return o;
    endfunction

    function automatic obs_t obs_now();
        return {DOM_RST_N, SYS_READY, BUSY, TIMEOUT_ERR, ERR_DOM};
    endfunction

    task automatic check(input string name, input obs_t got, input obs_t want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s @%0t: got dom=%b rdy=%b busy=%b terr=%b edom=%0d, want dom=%b rdy=%b busy=%b terr=%b edom=%0d",
                     name, $time, got.dom, got.rdy, got.busy, got.terr, got.edom,
                     want.dom, want.rdy, want.busy, want.terr, want.edom);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // Monitor: every edge with a pending expectation is compared.
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() > 0) check("scoreboard", obs_now(), exp_q.pop_front());
        end
    end

    logic [N-1:0] echo, cur_dom;
    int           edge_no;
    int           rise_edge [N];
    int           ready_edge;
    obs_t         last;

    // One clock of stimulus; DOM_ACK is a one-cycle-late echo of the expected DOM_RST_N.
    task automatic cycle(input bit sw, input logic [N-1:0] clr, input logic [N-1:0] set);
        logic [N-1:0] ack;
        obs_t         e;
        @(negedge CLK);
        last = obs_now();
        for (int i = 0; i < N; i++)
            if (rise_edge[i] == 0 && DOM_RST_N[i]) rise_edge[i] = edge_no;
        if (ready_edge == 0 && SYS_READY) ready_edge = edge_no;
        ack        = (echo | set) & ~clr;
        RST        = 1'b1;
        SW_RST_REQ = sw;
        DOM_ACK    = ack;
        model_step(sw, ack);
        echo    = cur_dom;
        e       = model_obs();
        cur_dom = e.dom;
        exp_q.push_back(e);
        edge_no++;
    endtask

    task automatic do_reset(input int hold);
        @(negedge CLK);
        RST        = 1'b0;
        SW_RST_REQ = 1'b0;
        DOM_ACK    = '0;
        #1;
        check("async_reset", obs_now(), RST_OBS);
        model_restart();
        echo       = '0;
        cur_dom    = '0;
        edge_no    = 0;
        ready_edge = 0;
        for (int i = 0; i < N; i++) rise_edge[i] = 0;
        for (int c = 0; c < hold; c++) begin
            if (c > 0) @(negedge CLK);
            exp_q.push_back(model_obs());
        end
    endtask

    logic [N-1:0] stuck, clr_m, set_m;
    bit           sw_r;

    initial begin
        do_reset(3);

        repeat (15) cycle(1'b0, '0, '0);
        check_int("dom0_rise_edge", rise_edge[0], 5);
        check_int("dom1_rise_edge", rise_edge[1], 8);
        check_int("dom2_rise_edge", rise_edge[2], 11);
        check_int("sys_ready_edge", ready_edge, 13);

        cycle(1'b1, '0, '0);
        cycle(1'b0, '0, '0);
        check("sw_restart_in_ready", last, RST_OBS);
        repeat (14) cycle(1'b0, '0, '0);

        cycle(1'b0, 3'b010, '0);
        cycle(1'b0, '0, '0);
        check("ack_drop_restart", last, RST_OBS);
        repeat (14) cycle(1'b0, '0, '0);

        cycle(1'b1, '0, '0);
        repeat (6) cycle(1'b0, '0, '0);
        cycle(1'b1, '0, 3'b111);
        cycle(1'b0, '0, '0);
        check("sw_beats_ack", last, RST_OBS);
        repeat (14) cycle(1'b0, '0, '0);

`ifdef RST_SEQ_TIMEOUT_EN
        cycle(1'b1, '0, '0);
        repeat (20) cycle(1'b0, 3'b010, '0);
        check("timeout_error", last, {3'b000, 1'b0, 1'b0, 1'b1, 3'd1});
        cycle(1'b1, '0, '0);
        cycle(1'b0, '0, '0);
        check("error_cleared", last, RST_OBS);
        repeat (14) cycle(1'b0, '0, '0);
`endif

        cycle(1'b1, '0, '0);
        repeat (12) cycle(1'b0, 3'b100, '0);
        check("wait_dom2", last, {3'b111, 1'b0, 1'b1, 1'b0, 3'd0});
        do_reset(2);
        repeat (15) cycle(1'b0, '0, '0);
        check_int("post_reset_dom0_rise", rise_edge[0], 5);
        check_int("post_reset_ready_edge", ready_edge, 13);

        stuck = '0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 149) == 0)
                stuck = ($urandom_range(0, 1) == 1) ? N'(1 << $urandom_range(0, N-1)) : '0;
            sw_r  = ($urandom_range(0, 99) == 0);
            clr_m = stuck;
            if ($urandom_range(0, 49) == 0) clr_m = clr_m | N'(1 << $urandom_range(0, N-1));
            set_m = ($urandom_range(0, 9) == 0) ? N'($urandom) : '0;
            if ($urandom_range(0, 599) == 0) do_reset(2);
            else cycle(sw_r, clr_m, set_m);
        end

        repeat (2) @(negedge CLK);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
